// File: rtl/addsub_pkg.sv
// Shared constants and types for the bit-serial adder/subtractor.
package addsub_pkg;

  localparam int DEF_WIDTH = 8;

  // Operation select carried on the 'sub' input
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/serial_addsub_if.sv
// Operand and result handshakes for serial_addsub.
interface serial_addsub_if #(
  parameter int WIDTH = addsub_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;

  // Producer/consumer side
  modport master (
    output in_valid, op_a, op_b, sub, cin, out_ready,
    input  in_ready, out_valid, result, cout, ovf, busy
  );

  // Arithmetic block side
  modport slave (
    input  in_valid, op_a, op_b, sub, cin, out_ready,
    output in_ready, out_valid, result, cout, ovf, busy
  );

endinterface

// File: rtl/addsub_bit_cell.sv
// One-bit full adder / full subtractor. For subtract, c is the borrow.
module addsub_bit_cell
  import addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic sub,
  output logic bit_o,
  output logic c_next
);

  // Sum/difference bit is the same for both ops; only the carry term differs
  always_comb begin
    bit_o = a ^ b ^ c;
    if (sub == OP_SUB) c_next = (~a & b) | (~(a ^ b) & c);
    else               c_next = (a & b) | (b & c) | (a & c);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract: one bit per clock, LSB first,
// through a single bit cell and a carry/borrow flop.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  serial_addsub_if.slave io
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0]    cnt;
  logic             c, sub_q, cout_q, ovf_q;
  logic             bit_s, c_nxt;
  logic             accept, last;

  assign accept = io.in_valid & io.in_ready;
  assign last   = (cnt == CW'(WIDTH - 1));

  addsub_bit_cell u_cell (
    .a      (sa[0]),
    .b      (sb[0]),
    .c      (c),
    .sub    (sub_q),
    .bit_o  (bit_s),
    .c_next (c_nxt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt    = state;
    io.in_ready  = (state == ST_IDLE) & ~rst;
    io.out_valid = (state == ST_DONE);
    io.busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (accept)       state_nxt = ST_RUN;
      ST_RUN:  if (last)         state_nxt = ST_DONE;
      ST_DONE: if (io.out_ready) state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, then shift one bit per clock while running.
  // result/cout/ovf are only written in RUN, so they hold through DONE and
  // after the output handshake until the next operation starts shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      sub_q  <= OP_ADD;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          sa    <= io.op_a;
          sb    <= io.op_b;
          sub_q <= io.sub;
          c     <= io.cin;
          cnt   <= '0;
        end
        ST_RUN: begin
          res <= {bit_s, res[WIDTH-1:1]};
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          c   <= c_nxt;
          cnt <= cnt + CW'(1);
          // Signed overflow: carry/borrow into the MSB differs from the one out
          if (last) begin
            cout_q <= c_nxt;
            ovf_q  <= c ^ c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.result = res;
  assign io.cout   = cout_q;
  assign io.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed plus randomized checks of serial_addsub against an arithmetic model.
module tb_serial_addsub;
  import addsub_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(W)) io ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  // Reference: plain integer arithmetic, returns {ovf, cout, result}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, b,
                                         input logic s, ci);
    int ua, ub, sa, sb, u, sv;
    logic [W-1:0] r;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    if (s == OP_SUB) begin
      u  = ua - ub - int'(ci);
      sv = sa - sb - int'(ci);
      co = (u < 0);
      r  = W'((u + 2**W) % 2**W);
    end else begin
      u  = ua + ub + int'(ci);
      sv = sa + sb + int'(ci);
      co = (u >= 2**W);
      r  = W'(u % 2**W);
    end
    ov = (sv > 2**(W-1) - 1) || (sv < -(2**(W-1)));
    return {ov, co, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_res(input string tag, input logic [W+1:0] e);
    chk({tag, "_result"}, 32'(io.result), 32'(e[W-1:0]));
    chk({tag, "_cout"},   32'(io.cout),   32'(e[W]));
    chk({tag, "_ovf"},    32'(io.ovf),    32'(e[W+1]));
  endtask

  // One complete operation with a chosen DONE hold time
  task automatic run_op(input string tag, input logic [W-1:0] a, b,
                        input logic s, ci, input int hold);
    logic [W+1:0] e;
    int n;
    e = model(a, b, s, ci);
    io.op_a = a; io.op_b = b; io.sub = s; io.cin = ci;
    io.in_valid = 1'b1;
    n = 0;
    while (!io.in_ready && n < 20) begin tick(); n++; end
    chk({tag, "_in_ready"}, 32'(io.in_ready), 32'd1);
    tick();
    io.in_valid = 1'b0;
    n = 0;
    while (!io.out_valid && n < 40) begin tick(); n++; end
    chk({tag, "_latency"}, 32'(n), 32'(W));
    repeat (hold) tick();
    chk({tag, "_valid"}, 32'(io.out_valid), 32'd1);
    chk_res(tag, e);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    chk({tag, "_released"}, 32'(io.out_valid), 32'd0);
  endtask

  initial begin
    logic [W+1:0] e, e2;
    logic [W+1:0] exp_q[$];
    logic [W-1:0] ra, rb;
    logic rs, rc;
    int n, acc, got, last_acc;

    rst = 1'b1;
    io.in_valid = 1'b0; io.out_ready = 1'b0;
    io.op_a = '0; io.op_b = '0; io.sub = OP_ADD; io.cin = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_busy",      32'(io.busy),      32'd0);
    chk("rst_in_ready",  32'(io.in_ready),  32'd0);
    chk("rst_result",    32'(io.result),    32'd0);
    chk("rst_cout",      32'(io.cout),      32'd0);
    chk("rst_ovf",       32'(io.ovf),       32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(io.in_ready), 32'd1);

    // Directed arithmetic cases
    run_op("add_5a_33", 8'h5A, 8'h33, OP_ADD, 1'b0, 0);
    chk("add_5a_33_lit", 32'(io.result), 32'h8D);
    run_op("sub_10_20", 8'h10, 8'h20, OP_SUB, 1'b0, 1);
    chk("sub_10_20_lit", 32'(io.result), 32'hF0);
    run_op("add_ff_01_c", 8'hFF, 8'h01, OP_ADD, 1'b1, 0);
    chk("add_ff_01_lit", 32'(io.result), 32'h01);
    run_op("sub_80_01", 8'h80, 8'h01, OP_SUB, 1'b0, 0);
    chk("sub_80_01_ovf_lit", 32'(io.ovf), 32'd1);

    // Backpressure in DONE while new operands wait on the input
    e = model(8'h7F, 8'h01, OP_ADD, 1'b0);
    io.op_a = 8'h7F; io.op_b = 8'h01; io.sub = OP_ADD; io.cin = 1'b0;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    n = 0;
    while (!io.out_valid && n < 40) begin tick(); n++; end
    chk("bp_latency", 32'(n), 32'(W));
    e2 = model(8'h0C, 8'h05, OP_SUB, 1'b1);
    io.op_a = 8'h0C; io.op_b = 8'h05; io.sub = OP_SUB; io.cin = 1'b1;
    io.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(io.out_valid), 32'd1);
      chk("bp_in_ready", 32'(io.in_ready), 32'd0);
      chk_res("bp_hold", e);
    end
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    chk("bp_idle_valid", 32'(io.out_valid), 32'd0);
    chk("bp_idle_ready", 32'(io.in_ready), 32'd1);
    chk("bp_idle_busy",  32'(io.busy), 32'd0);
    tick();
    io.in_valid = 1'b0;
    chk("bp_taken_busy", 32'(io.busy), 32'd1);
    n = 0;
    while (!io.out_valid && n < 40) begin tick(); n++; end
    chk("bp_next_latency", 32'(n), 32'(W));
    chk_res("bp_next", e2);
    io.out_ready = 1'b1; tick(); io.out_ready = 1'b0;

    // Reset during the third RUN cycle; a set carry-in must not leak forward
    io.op_a = 8'hAA; io.op_b = 8'h55; io.sub = OP_ADD; io.cin = 1'b1;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(io.out_valid), 32'd0);
    chk("mid_rst_busy",  32'(io.busy), 32'd0);
    chk("mid_rst_ready", 32'(io.in_ready), 32'd1);
    run_op("after_rst", 8'h01, 8'h01, OP_ADD, 1'b0, 0);
    chk("after_rst_lit", 32'(io.result), 32'h02);

    // Randomized single operations with random DONE hold
    for (int k = 0; k < 12; k++) begin
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    // Back-to-back: in_valid and out_ready both held high. Each operation
    // spends WIDTH cycles in RUN, one in DONE and one in IDLE, so accepts
    // land WIDTH+2 edges apart.
    ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
    io.op_a = ra; io.op_b = rb; io.sub = rs; io.cin = rc;
    io.in_valid = 1'b1; io.out_ready = 1'b1;
    acc = 0; got = 0; last_acc = -1;
    for (int k = 0; k < 100 && got < 3; k++) begin
      n = 0;
      if (io.in_valid && io.in_ready) begin
        exp_q.push_back(model(ra, rb, rs, rc));
        if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'(W + 2));
        last_acc = cyc;
        acc++;
        n = 1;
      end
      if (io.out_valid) begin
        if (exp_q.size() > 0) chk_res("b2b", exp_q.pop_front());
        else chk("b2b_unexpected_result", 32'd1, 32'd0);
        got++;
      end
      tick();
      if (n == 1) begin
        ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
        io.op_a = ra; io.op_b = rb; io.sub = rs; io.cin = rc;
        if (acc == 3) io.in_valid = 1'b0;
      end
    end
    chk("b2b_results", 32'(got), 32'd3);
    io.in_valid = 1'b0; io.out_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
